// File: rtl/mem_arbiter.sv
// ---------------------------------------------------------------------------
// mem_arbiter
//   Round-robin arbiter and burst sequencer between N cache channels and a
//   single-word main-memory port. One channel is granted at a time; its
//   access (1..MAX_BURST words) is split into word beats on the memory port.
//   Read beats are gathered into a wide line returned on ch_rdata, and the
//   granted channel sees a one-cycle DONE status when the burst completes.
//
// Handshake (memory side): the arbiter raises mem_req and holds mem_we,
//   mem_addr and mem_wdata stable until an edge where mem_ack=1. That edge
//   completes the beat: read data on mem_rdata is captured on that edge. A
//   beat may follow back-to-back with mem_req staying high. mem_ack is
//   ignored while mem_req=0.
//
// Ports
//   clk, rst_n       clock (rising edge) / asynchronous active-low reset
//   ch_vis_signal    per ch 2 bits: 00 none, 01 read, 10 write, 11 none
//   ch_addr          per ch base byte address (word aligned)
//   ch_length        per ch beat count (0 -> 1, >MAX_BURST -> MAX_BURST)
//   ch_wdata         per ch write line, word k = beat k
//   ch_status        per ch 2 bits: 00 idle, 01 busy, 10 done (1 cycle)
//   ch_rdata         shared read line, word k = beat k
//   mem_req/mem_we/mem_addr/mem_wdata   beat request to memory
//   mem_ack/mem_rdata                   beat completion / read data
//   dbg_state        current FSM state (IDLE=0, ISSUE=1, DONE=2)
//
// Optional feature: define MEM_ARB_PERF_CNT_EN to add perf_grant_cnt and
//   perf_wait_cnt (32-bit saturating counters per channel).
// ---------------------------------------------------------------------------
module mem_arbiter #(
  parameter int NUM_CH     = 2,
  parameter int CH_IDX     = 1,
  parameter int ADDR_WIDTH = 17,
  parameter int LEN        = 32,
  parameter int MAX_BURST  = 8,
  parameter int BURST_IDX  = 3
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic [2*NUM_CH-1:0]                  ch_vis_signal,
  input  logic [ADDR_WIDTH*NUM_CH-1:0]         ch_addr,
  input  logic [(BURST_IDX+1)*NUM_CH-1:0]      ch_length,
  input  logic [LEN*MAX_BURST*NUM_CH-1:0]      ch_wdata,
  output logic [2*NUM_CH-1:0]                  ch_status,
  output logic [LEN*MAX_BURST-1:0]             ch_rdata,
  output logic                                 mem_req,
  output logic                                 mem_we,
  output logic [ADDR_WIDTH-1:0]                mem_addr,
  output logic [LEN-1:0]                       mem_wdata,
  input  logic                                 mem_ack,
  input  logic [LEN-1:0]                       mem_rdata,
  output logic [1:0]                           dbg_state
`ifdef MEM_ARB_PERF_CNT_EN
  ,
  output logic [32*NUM_CH-1:0]                 perf_grant_cnt,
  output logic [32*NUM_CH-1:0]                 perf_wait_cnt
`endif
);

  localparam int LW   = BURST_IDX + 1;
  localparam int LINE = LEN * MAX_BURST;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [CH_IDX-1:0]     ch_q, ch_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] base_q, base_d;
  logic [LW-1:0]         nbeats_q, nbeats_d;
  logic [BURST_IDX-1:0]  beat_q, beat_d;
  logic [LINE-1:0]       wline_q, wline_d;
  logic [LINE-1:0]       rline_q, rline_d;
  logic [CH_IDX-1:0]     last_q, last_d;

  logic [NUM_CH-1:0]     req_vec;
  logic                  grant_vld;
  logic [CH_IDX-1:0]     grant_ch;
  logic [LW-1:0]         len_raw;
  logic [LW-1:0]         len_eff;

  // Only read/write codes count as a request; 11 is treated as none.
  always_comb begin
    req_vec = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      req_vec[c] = (ch_vis_signal[2*c +: 2] == 2'b01) ||
                   (ch_vis_signal[2*c +: 2] == 2'b10);
    end
  end

  // Round-robin scan starting one past the last granted channel.
  always_comb begin
    int idx;
    idx       = 0;
    grant_vld = 1'b0;
    grant_ch  = '0;
    for (int i = 1; i <= NUM_CH; i++) begin
      idx = (int'(last_q) + i) % NUM_CH;
      if (!grant_vld && req_vec[idx]) begin
        grant_vld = 1'b1;
        grant_ch  = CH_IDX'(idx);
      end
    end
  end

  // Beat-count clamp: zero means a single beat, oversize caps at MAX_BURST.
  always_comb begin
    len_raw = ch_length[grant_ch*LW +: LW];
    if (len_raw == '0) begin
      len_eff = LW'(1);
    end else if (len_raw > LW'(MAX_BURST)) begin
      len_eff = LW'(MAX_BURST);
    end else begin
      len_eff = len_raw;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      ch_q     <= '0;
      we_q     <= 1'b0;
      base_q   <= '0;
      nbeats_q <= LW'(1);
      beat_q   <= '0;
      wline_q  <= '0;
      rline_q  <= '0;
      last_q   <= CH_IDX'(NUM_CH - 1);
    end else begin
      state_q  <= state_d;
      ch_q     <= ch_d;
      we_q     <= we_d;
      base_q   <= base_d;
      nbeats_q <= nbeats_d;
      beat_q   <= beat_d;
      wline_q  <= wline_d;
      rline_q  <= rline_d;
      last_q   <= last_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    ch_d     = ch_q;
    we_d     = we_q;
    base_d   = base_q;
    nbeats_d = nbeats_q;
    beat_d   = beat_q;
    wline_d  = wline_q;
    rline_d  = rline_q;
    last_d   = last_q;
    case (state_q)
      ST_IDLE: begin
        if (grant_vld) begin
          // Latch the whole request so later requester changes are ignored.
          ch_d     = grant_ch;
          we_d     = (ch_vis_signal[grant_ch*2 +: 2] == 2'b10);
          base_d   = ch_addr[grant_ch*ADDR_WIDTH +: ADDR_WIDTH];
          nbeats_d = len_eff;
          beat_d   = '0;
          wline_d  = ch_wdata[grant_ch*LINE +: LINE];
          rline_d  = '0;
          last_d   = grant_ch;
          state_d  = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (mem_ack) begin
          if (!we_q) begin
            rline_d[beat_q*LEN +: LEN] = mem_rdata;
          end
          if (LW'(beat_q) == nbeats_q - LW'(1)) begin
            state_d = ST_DONE;
          end else begin
            beat_d = beat_q + BURST_IDX'(1);
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Memory port is driven only while issuing; zero otherwise.
  always_comb begin
    mem_req   = (state_q == ST_ISSUE);
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (state_q == ST_ISSUE) begin
      mem_we    = we_q;
      mem_addr  = base_q + (ADDR_WIDTH'(beat_q) << 2);
      mem_wdata = wline_q[beat_q*LEN +: LEN];
    end
  end

  // Status is partly combinational from requests, so reset gates it too.
  always_comb begin
    ch_status = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (!rst_n) begin
        ch_status[2*c +: 2] = 2'b00;
      end else if ((state_q != ST_IDLE) && (ch_q == CH_IDX'(c))) begin
        ch_status[2*c +: 2] = (state_q == ST_DONE) ? 2'b10 : 2'b01;
      end else begin
        ch_status[2*c +: 2] = req_vec[c] ? 2'b01 : 2'b00;
      end
    end
  end

  assign ch_rdata  = rline_q;
  assign dbg_state = state_q;

`ifdef MEM_ARB_PERF_CNT_EN
  logic [31:0]       grant_cnt_q [NUM_CH];
  logic [31:0]       wait_cnt_q  [NUM_CH];
  logic [NUM_CH-1:0] grant_now;
  logic [NUM_CH-1:0] wait_now;

  // A channel waits when it requests but neither owns the port nor is
  // being granted on this edge.
  always_comb begin
    grant_now = '0;
    wait_now  = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      grant_now[c] = (state_q == ST_IDLE) && grant_vld && (grant_ch == CH_IDX'(c));
      wait_now[c]  = req_vec[c] && !grant_now[c] &&
                     !((state_q != ST_IDLE) && (ch_q == CH_IDX'(c)));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < NUM_CH; c++) begin
        grant_cnt_q[c] <= '0;
        wait_cnt_q[c]  <= '0;
      end
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (grant_now[c] && (grant_cnt_q[c] != 32'hFFFF_FFFF)) begin
          grant_cnt_q[c] <= grant_cnt_q[c] + 32'd1;
        end
        if (wait_now[c] && (wait_cnt_q[c] != 32'hFFFF_FFFF)) begin
          wait_cnt_q[c] <= wait_cnt_q[c] + 32'd1;
        end
      end
    end
  end

  always_comb begin
    perf_grant_cnt = '0;
    perf_wait_cnt  = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      perf_grant_cnt[32*c +: 32] = grant_cnt_q[c];
      perf_wait_cnt[32*c +: 32]  = wait_cnt_q[c];
    end
  end
`endif

endmodule
